// File: rtl/apb_pkg.sv
// Shared APB requester definitions: FSM states, UART register map,
// default bus timeout and the timeout counter width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    localparam logic [31:0] UART_RX_ADDR = 32'h78;
    localparam logic [31:0] UART_TX_ADDR = 32'h79;

    localparam int DEFAULT_TIMEOUT = 1024;

    // A limit of 0 disables the timeout; keep a 1-bit counter then.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-cycle counter for the APB requester.
// Ports: pclk, rst (sync, high), clr, en -> hit (count == LIMIT).
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic pclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    // Stops at LIM so a long stall never wraps back below the limit.
    always_ff @(posedge pclk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (LIMIT != 0) && (cnt == LIM);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in,
// SETUP/ACCESS transfer out, one-cycle response pulse with timeout.
// Ports: pclk, rst (sync, high); cmd_* command stream; rsp_* response;
// psel/penable/pwrite/padd/pwdata/pstrb bus out; pready/prdata/pslevrr in.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   padd,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslevrr
);

    apb_state_t state;
    logic       accept;
    logic       to_hit;

    assign accept = (state == IDLE) && cmd_valid;

    // Counts ACCESS cycles that end without pready.
    apb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .pclk (pclk),
        .rst  (rst),
        .clr  (accept),
        .en   ((state == ACCESS) && !pready),
        .hit  (to_hit)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            padd        <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= cmd_write;
                        padd      <= cmd_addr;
                        // Reads never carry data or strobes.
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // A late pready on the limit cycle still wins.
                    if (pready) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslevrr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                    end else if (to_hit) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a scripted APB slave.
// Table of transfers plus reset and busy-hold sequences.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 16;

    logic        pclk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] padd;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslevrr;

    apb_master #(
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (32),
        .DATA_W         (32)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .padd        (padd),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .prdata      (prdata),
        .pslevrr     (pslevrr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Scripted slave: pready after sl_waits ACCESS cycles, never if < 0.
    int          sl_waits;
    logic        sl_err;
    logic [31:0] sl_rdata;
    int          acc_cnt;

    always @(posedge pclk) begin
        if (psel && penable) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
    end

    assign pready  = psel && penable && (sl_waits >= 0)
                     && (acc_cnt == sl_waits);
    assign prdata  = sl_rdata;
    assign pslevrr = sl_err;

    int checks;
    int errors;
    int rsp_cnt;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Bus-stability monitor over SETUP and every ACCESS cycle.
    logic        mon_on;
    logic        mon_write;
    logic [31:0] mon_addr;
    logic [31:0] mon_wdata;
    logic [3:0]  mon_strb;

    always @(negedge pclk) begin
        if (rsp_valid) rsp_cnt++;
        if (mon_on && psel) begin
            chk("bus_pwrite", 64'(pwrite), 64'(mon_write));
            chk("bus_padd", 64'(padd), 64'(mon_addr));
            chk("bus_pwdata", 64'(pwdata), 64'(mon_wdata));
            chk("bus_pstrb", 64'(pstrb), 64'(mon_strb));
        end
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        slverr;
        logic [31:0] sdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } vec_t;

    vec_t vecs[8];

    // Present a command and hold it until the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit done;
        done      = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (cmd_ready) done = 1;
            @(posedge pclk);
            #1;
        end
        if (!done) chk("issue_timeout", 64'(0), 64'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c;
        bit got;
        sl_waits  = v.waits;
        sl_err    = v.slverr;
        sl_rdata  = v.sdata;
        mon_write = v.write;
        mon_addr  = v.addr;
        mon_wdata = v.write ? v.wdata : 32'h0;
        mon_strb  = v.write ? v.strb : 4'h0;
        mon_on    = 1'b1;
        issue(v.write, v.addr, v.wdata, v.strb);
        c   = 0;
        got = 0;
        while (!got && c < 60) begin
            @(negedge pclk);
            c++;
            if (c == 1)
                chk($sformatf("v%0d_setup", idx),
                    64'({psel, penable}), 64'(2'b10));
            if (c == 2)
                chk($sformatf("v%0d_access", idx),
                    64'({psel, penable}), 64'(2'b11));
            if (rsp_valid) got = 1;
        end
        chk($sformatf("v%0d_latency", idx), 64'(c), 64'(v.lat));
        chk($sformatf("v%0d_rdata", idx), 64'(rsp_rdata), 64'(v.rdata));
        chk($sformatf("v%0d_err", idx), 64'(rsp_err), 64'(v.err));
        chk($sformatf("v%0d_tmo", idx), 64'(rsp_timeout), 64'(v.tmo));
        chk($sformatf("v%0d_resp_bus", idx),
            64'({psel, penable, cmd_ready}), 64'(3'b000));
        mon_on = 1'b0;
        @(negedge pclk);
        chk($sformatf("v%0d_idle", idx),
            64'({cmd_ready, rsp_valid}), 64'(2'b10));
        chk($sformatf("v%0d_hold", idx), 64'(rsp_rdata), 64'(v.rdata));
    endtask

    initial begin
        int c;
        int snap;
        checks    = 0;
        errors    = 0;
        rsp_cnt   = 0;
        mon_on    = 1'b0;
        sl_waits  = 0;
        sl_err    = 1'b0;
        sl_rdata  = 32'h0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;

        //         w   addr          wdata         strb  wt  se  sdata  lat rdata  err to
        vecs[0] = '{1, UART_TX_ADDR, 32'hE7,       4'h1, 0,  0, 32'h0,  3,  32'h0,  0, 0};
        vecs[1] = '{0, UART_RX_ADDR, 32'h99,       4'hF, 5,  0, 32'hE6, 8,  32'hE6, 0, 0};
        vecs[2] = '{1, UART_TX_ADDR, 32'h41,       4'h1, 1,  1, 32'h77, 4,  32'h0,  1, 0};
        vecs[3] = '{0, UART_RX_ADDR, 32'h0,        4'h0, 0,  1, 32'hA5, 3,  32'hA5, 1, 0};
        vecs[4] = '{1, 32'h1000,     32'hDEADBEEF, 4'hF, 3,  0, 32'h0,  6,  32'h0,  0, 0};
        vecs[5] = '{0, UART_RX_ADDR, 32'h0,        4'h0, -1, 0, 32'h55, 19, 32'h0,  1, 1};
        vecs[6] = '{1, UART_TX_ADDR, 32'h5A,       4'h3, 15, 0, 32'h0,  18, 32'h0,  0, 0};
        vecs[7] = '{0, UART_RX_ADDR, 32'h0,        4'h0, 16, 0, 32'h3C, 19, 32'h3C, 0, 0};

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_ctrl", 64'({cmd_ready, psel, penable, pwrite}),
            64'(4'b1000));
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
        chk("rst_data", {padd, pwdata}, 64'(0));
        chk("rst_misc", 64'({pstrb, rsp_rdata}), 64'(0));
        @(posedge pclk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset while waiting in ACCESS: bus drops, no response.
        sl_waits = 10;
        sl_rdata = 32'h11;
        issue(1'b0, UART_RX_ADDR, 32'h0, 4'h0);
        repeat (3) @(negedge pclk);
        chk("mid_access", 64'({psel, penable}), 64'(2'b11));
        snap = rsp_cnt;
        rst  = 1'b1;
        @(posedge pclk);
        #1;
        chk("mid_rst_bus", 64'({psel, penable, cmd_ready}),
            64'(3'b001));
        rst = 1'b0;
        repeat (20) @(negedge pclk);
        chk("mid_rst_norsp", 64'(rsp_cnt), 64'(snap));

        // Busy hold: second command raised during ACCESS of the first.
        sl_waits = 2;
        sl_err   = 1'b0;
        sl_rdata = 32'h22;
        issue(1'b1, UART_TX_ADDR, 32'h11, 4'h1);
        c = 0;
        while (!rsp_valid && c < 40) begin
            @(negedge pclk);
            c++;
            if (c == 2) begin
                sl_waits  = 2;
                cmd_valid = 1'b1;
                cmd_write = 1'b0;
                cmd_addr  = UART_RX_ADDR;
                cmd_wdata = 32'hCAFE;
                cmd_strb  = 4'hF;
            end
            if (c >= 2)
                chk($sformatf("busy_c%0d", c), 64'(cmd_ready), 64'(0));
        end
        chk("busy_a_lat", 64'(c), 64'(5));
        @(negedge pclk);
        chk("busy_idle_rdy", 64'(cmd_ready), 64'(1));
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        sl_waits = 0;
        @(negedge pclk);
        chk("busy_b_setup", 64'({psel, penable, pwrite}), 64'(3'b100));
        chk("busy_b_addr", 64'(padd), 64'(UART_RX_ADDR));
        chk("busy_b_wd", 64'({pwdata, pstrb}), 64'(0));
        c = 1;
        while (!rsp_valid && c < 40) begin
            @(negedge pclk);
            c++;
        end
        chk("busy_b_lat", 64'(c), 64'(3));
        chk("busy_b_rdata", 64'(rsp_rdata), 64'(32'h22));
        chk("busy_b_err", 64'({rsp_err, rsp_timeout}), 64'(0));

        repeat (2) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a simple valid/ready command stream into compliant SETUP/ACCESS transfers. It is the initiator side of the same bus that `uart_apb` responds on, and it replaces bench-only driver tasks with synthesizable logic. The target use is a controller writing TX bytes to and reading RX bytes from the UART slave. It also adds a bus timeout so that a hung slave cannot stall the controller.

## Interface
- `TIMEOUT_CYCLES`, 1024: the maximum number of ACCESS cycles to wait for `pready`. A value of 0 disables the timeout.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. `pstrb` is `DATA_W/8` bits wide.

Ports, clock and reset first:
- `pclk` in 1: clock. The design has one clock only.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block accepts a command.
- `cmd_write` in 1: 1 selects a write, 0 selects a read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data.
- `cmd_strb` in DATA_W/8: byte enables for a write.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: read data.
- `rsp_err` out 1: the slave error or a timeout occurred.
- `rsp_timeout` out 1: the transfer was aborted by the timeout.
- `psel`, `penable`, `pwrite` out 1: APB control signals.
- `padd` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `pstrb` out DATA_W/8: APB byte strobes.
- `pready` in 1: slave ready.
- `prdata` in DATA_W: slave read data.
- `pslevrr` in 1: slave error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - When `cmd_valid` is 1, the block latches write, addr, wdata and strb, then goes to SETUP.
- **SETUP:**
  - `psel`=1, `penable`=0. The latched fields drive the bus.
  - The FSM always moves to ACCESS after one cycle.
- **ACCESS:**
  - `psel`=1, `penable`=1.
  - If `pready`=1, the block captures `pslevrr`. On a read it also captures `prdata`. It then goes to RESP.
  - Otherwise the timeout counter increments.
  - When the counter reaches `TIMEOUT_CYCLES` and `pready` is still 0, the block aborts and goes to RESP with `rsp_timeout`=1 and `rsp_err`=1.
- **RESP:**
  - `rsp_valid`=1 for exactly one cycle. `psel` and `penable` are 0.
  - The FSM then returns to IDLE.
- **Bus field rules:**
  - `padd`, `pwrite`, `pwdata` and `pstrb` stay stable from SETUP through the final ACCESS cycle.
  - On reads, `pstrb` is driven to 0 and `pwdata` is driven to 0.
- **Response field rules:**
  - On writes and on timeouts, `rsp_rdata`=0.
  - On a read completion with `pslevrr`=1, `rsp_rdata` carries the captured `prdata` and `rsp_err`=1.
- **Unaccepted commands:** commands presented while `cmd_ready`=0 are ignored. The requester must hold them.
- **Counter:** width is `$clog2(TIMEOUT_CYCLES+1)`. It clears on entry to SETUP and saturates without wrapping.
- **Reset:**
  - Reset values: all outputs are 0 except `cmd_ready`=1. The FSM is in IDLE and the counter is 0.
  - A reset in the middle of a transfer drops `psel` and `penable` at that edge and produces no `rsp_valid`.

## Timing
- Command accepted at edge N (IDLE, `cmd_valid`=1): SETUP is visible in cycle N+1 and ACCESS in cycle N+2.
- Zero-wait slave: `pready`=1 in the first ACCESS cycle gives `rsp_valid` in cycle N+3.
- Each wait cycle adds one cycle to that latency.
- Back-to-back throughput is one transfer per 4 cycles: the next command is accepted in the cycle after RESP.
- Timeout: `rsp_valid` is asserted in cycle N+3+`TIMEOUT_CYCLES`.
- `rsp_*` fields are valid only while `rsp_valid`=1. They hold their values until the next RESP.
- `pready` is sampled only while the FSM is in ACCESS.

## Structure
- A shared package `apb_pkg` holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - UART register addresses `UART_RX_ADDR`=32'h78 and `UART_TX_ADDR`=32'h79;
  - the default timeout.
- The only sub-module is `apb_timeout_counter`: a saturating counter with clear, enable and a `hit` output.

## Test plan
- **Write, zero wait:** write 0xE7 to 0x79 with strb 4'b0001 and the slave `pready` tied to 1. Required response:
  - `psel` rises at N+1 and `penable` at N+2;
  - `padd`=0x79, `pwdata`=0xE7;
  - `rsp_valid` at N+3 with `rsp_err`=0 and `rsp_rdata`=0.
- **Read with waits:** read 0x78 with `pready` held low for 5 ACCESS cycles and `prdata`=0xE6. Required response:
  - `pstrb`=0 throughout;
  - the bus stays stable throughout;
  - `rsp_valid` at N+8 with `rsp_rdata`=0xE6.
- **Slave error:** write 0x79 with `pslevrr`=1 in the `pready` cycle. Required response: `rsp_err`=1 and `rsp_timeout`=0.
- **Timeout:** set `TIMEOUT_CYCLES`=16 and keep `pready`=0 forever. Required response:
  - `rsp_valid` at N+19 with `rsp_timeout`=1 and `rsp_err`=1;
  - `psel` returns to 0;
  - a following command is accepted normally.
- **Reset mid-ACCESS:** assert `rst` during a waited transfer. Required response:
  - at the next edge `psel`=`penable`=0 and `cmd_ready`=1;
  - no `rsp_valid` pulse.
- **Busy hold:** raise `cmd_valid` with a second command during ACCESS. Required response:
  - `cmd_ready` stays 0 until the cycle after RESP;
  - the second command is issued unchanged.
